// File: rtl/dsp_seq_pkg.sv
// rtl/dsp_seq_pkg.sv - shared types and DSP opmode constants for the MAC sequencer
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [7:0] OPM_IDLE    = 8'h00;
    localparam logic [7:0] OPM_FIRST   = 8'h01;
    localparam logic [7:0] OPM_ACC     = 8'h09;
    localparam int         OPM_SUB_BIT = 7;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tok_t;

    // First beat loads P from M, later beats fold M into P; bit 7 flips the sign of M.
    function automatic logic [7:0] opmode_for(input tok_t t, input logic sub);
        logic [7:0] opm;
        opm = t.first ? OPM_FIRST : OPM_ACC;
        opm[OPM_SUB_BIT] = sub;
        return t.valid ? opm : OPM_IDLE;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - operand stream and result handshake bundle
interface dsp_mac_sequencer_if;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_a;
    logic [17:0] s_b;
    logic        r_valid;
    logic        r_ready;
    logic [47:0] r_data;

    modport master (
        output s_valid, s_a, s_b, r_ready,
        input  s_ready, r_valid, r_data
    );

    modport slave (
        input  s_valid, s_a, s_b, r_ready,
        output s_ready, r_valid, r_data
    );
endinterface

// File: rtl/dsp_tok_delay.sv
// rtl/dsp_tok_delay.sv - 0/1-stage token delay tracking one DSP pipeline register
module dsp_tok_delay
    import dsp_seq_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tok_t tok_i,
    output tok_t tok_o
);

    generate
        if (STAGES == 0) begin : g_pass
            assign tok_o = tok_i;
        end else begin : g_reg
            tok_t tok_q;

            // Mirror the DSP register so the token lines up with the data it describes
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) tok_q <= '0;
                else        tok_q <= tok_i;
            end

            assign tok_o = tok_q;
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - job controller running a DSP slice as a MAC/MSC engine
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int MREG  = 1,
    parameter int PREG  = 1,
    parameter int CNT_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     len_m1,
    input  logic                 sub,
    output logic                 busy,
    dsp_mac_sequencer_if.slave   strm,
    output logic [17:0]          dsp_a,
    output logic [17:0]          dsp_b,
    output logic [7:0]           dsp_opmode,
    output logic                 dsp_cem,
    output logic                 dsp_cep,
    output logic                 dsp_rstm,
    output logic                 dsp_rstp,
    input  logic [47:0]          dsp_p
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic             sub_q;
    logic [17:0]      a_q;
    logic [17:0]      b_q;
    logic             r_valid_q;
    logic [47:0]      r_data_q;
    tok_t             t0_q;
    tok_t             t1;
    tok_t             t2;

    logic accept;
    logic last_beat;
    logic done;
    logic unused_t2_first;

    assign accept          = strm.s_valid && (state_q == ST_LOAD);
    assign last_beat       = (cnt_q == len_q);
    assign done            = t2.valid && t2.last;
    assign unused_t2_first = t2.first;

    // Job FSM, beat counter, operand registers and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            sub_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            t0_q      <= '0;
        end else begin
            t0_q <= '{valid: accept,
                      first: accept && (cnt_q == '0),
                      last:  accept && last_beat};
            if (accept) begin
                a_q   <= strm.s_a;
                b_q   <= strm.s_b;
                cnt_q <= cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        len_q   <= len_m1;
                        sub_q   <= sub;
                        cnt_q   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept && last_beat) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (done) begin
                        state_q   <= ST_HOLD;
                        r_valid_q <= 1'b1;
                        r_data_q  <= dsp_p;
                    end
                end
                ST_HOLD: begin
                    if (strm.r_ready) begin
                        r_valid_q <= 1'b0;
                        if (start) begin
                            state_q <= ST_LOAD;
                            len_q   <= len_m1;
                            sub_q   <= sub;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    dsp_tok_delay #(.STAGES(MREG)) u_mdelay (
        .clk   (clk),
        .rst_n (rst_n),
        .tok_i (t0_q),
        .tok_o (t1)
    );

    dsp_tok_delay #(.STAGES(PREG)) u_pdelay (
        .clk   (clk),
        .rst_n (rst_n),
        .tok_i (t1),
        .tok_o (t2)
    );

    assign busy         = (state_q != ST_IDLE);
    assign strm.s_ready = (state_q == ST_LOAD);
    assign strm.r_valid = r_valid_q;
    assign strm.r_data  = r_data_q;
    assign dsp_a        = a_q;
    assign dsp_b        = b_q;
    assign dsp_cem      = t0_q.valid;
    assign dsp_cep      = t1.valid;
    assign dsp_opmode   = opmode_for(t1, sub_q);
    assign dsp_rstm     = (state_q == ST_IDLE);
    assign dsp_rstp     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - scoreboard bench for dsp_mac_sequencer with a behavioural DSP slice
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  len_m1 = '0;
    logic        sub = 1'b0;
    logic        busy;
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_cem, dsp_cep, dsp_rstm, dsp_rstp;
    logic [47:0] dsp_p;

    dsp_mac_sequencer_if sif ();

    dsp_mac_sequencer #(.MREG(1), .PREG(1), .CNT_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len_m1     (len_m1),
        .sub        (sub),
        .busy       (busy),
        .strm       (sif.slave),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_cem    (dsp_cem),
        .dsp_cep    (dsp_cep),
        .dsp_rstm   (dsp_rstm),
        .dsp_rstp   (dsp_rstp),
        .dsp_p      (dsp_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DSP slice with MREG=1, PREG=1: M = A*B, P = (P or 0) +/- M
    logic signed [35:0] m_q;
    logic [47:0]        p_q;
    logic [47:0]        m_ext;
    assign m_ext = {{12{m_q[35]}}, m_q};
    assign dsp_p = p_q;
    always @(posedge clk) begin
        if (dsp_rstm)     m_q <= '0;
        else if (dsp_cem) m_q <= $signed(dsp_a) * $signed(dsp_b);
        if (dsp_rstp)     p_q <= '0;
        else if (dsp_cep) p_q <= (dsp_opmode[3] ? p_q : 48'd0) +
                                 (dsp_opmode[0] ? (dsp_opmode[7] ? (48'd0 - m_ext) : m_ext) : 48'd0);
    end

    int opm_cnt [256];
    always @(negedge clk) opm_cnt[dsp_opmode] <= opm_cnt[dsp_opmode] + 1;

    int          checks = 0;
    int          passed = 0;
    int          qa[$];
    int          qb[$];
    logic [47:0] sb[$];
    int          last_acc;
    int          first_acc;

    function automatic logic [47:0] exp_of(input bit s);
        logic [47:0] acc;
        longint      p;
        acc = '0;
        foreach (qa[i]) begin
            p   = longint'(qa[i]) * longint'(qb[i]);
            acc = s ? acc - 48'(p) : acc + 48'(p);
        end
        return acc;
    endfunction

    task automatic start_job(input bit s);
        start  = 1'b1;
        len_m1 = 10'(qa.size() - 1);
        sub    = s;
        sb.push_back(exp_of(s));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input bit bubbles);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < qa.size() && guard < 5000) begin
            sif.s_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            sif.s_a = 18'(qa[i]);
            sif.s_b = 18'(qb[i]);
            @(negedge clk);
            if (sif.s_valid && sif.s_ready) begin
                if (i == 0) first_acc = cyc + 1;
                last_acc = cyc + 1;
                i++;
            end
            @(posedge clk); #1;
            guard++;
        end
        sif.s_valid = 1'b0;
        checks++;
        if (i != qa.size()) $display("FAIL feed_timeout accepted %0d beats, required %0d", i, qa.size());
        else passed++;
    endtask

    task automatic wait_rv(output int at);
        int g;
        g  = 0;
        at = -1;
        while (sif.r_valid !== 1'b1 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (sif.r_valid === 1'b1) at = cyc;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, sif.s_ready, sif.r_valid, dsp_cem, dsp_cep, dsp_rstm, dsp_rstp} !== 7'b0000011)
            $display("FAIL reset_ctrl got %b required 0000011", {busy, sif.s_ready, sif.r_valid, dsp_cem, dsp_cep, dsp_rstm, dsp_rstp});
        else passed++;
        checks++;
        if (sif.r_data !== 48'd0) $display("FAIL reset_rdata got %h required 0", sif.r_data);
        else passed++;
        checks++;
        if ({dsp_a, dsp_b, dsp_opmode} !== 44'd0) $display("FAIL reset_dsp got a=%h b=%h opm=%h required 0", dsp_a, dsp_b, dsp_opmode);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_accumulate;
        int rv, s01, s09;
        logic [47:0] exp;
        qa = '{3, -2, 7, 1};
        qb = '{4, 5, 7, -1};
        s01 = opm_cnt[8'h01];
        s09 = opm_cnt[8'h09];
        start_job(1'b0);
        checks++;
        if (sif.s_ready !== 1'b1) $display("FAIL acc_sready_after_start got %b required 1", sif.s_ready);
        else passed++;
        feed(1'b0);
        wait_rv(rv);
        checks++;
        if (rv - last_acc !== 3) $display("FAIL acc_latency got %0d required 3", rv - last_acc);
        else passed++;
        exp = sb.pop_front();
        checks++;
        if (sif.r_data !== exp || exp !== 48'd50) $display("FAIL acc_result got %h required %h (50)", sif.r_data, exp);
        else passed++;
        checks++;
        if (opm_cnt[8'h01] - s01 !== 1 || opm_cnt[8'h09] - s09 !== 3)
            $display("FAIL acc_opmodes got 01x%0d 09x%0d required 01x1 09x3", opm_cnt[8'h01] - s01, opm_cnt[8'h09] - s09);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || sif.r_valid !== 1'b0) $display("FAIL acc_idle_after got busy=%b rv=%b required 0 0", busy, sif.r_valid);
        else passed++;
    endtask

    task automatic test_subtract;
        int rv, s81, s89;
        logic [47:0] exp;
        qa = '{1, 2, 3};
        qb = '{1, 2, 3};
        s81 = opm_cnt[8'h81];
        s89 = opm_cnt[8'h89];
        start_job(1'b1);
        feed(1'b0);
        wait_rv(rv);
        exp = sb.pop_front();
        checks++;
        if (sif.r_data !== exp || exp !== 48'hFFFF_FFFF_FFF2) $display("FAIL sub_result got %h required %h", sif.r_data, exp);
        else passed++;
        checks++;
        if (opm_cnt[8'h81] - s81 !== 1 || opm_cnt[8'h89] - s89 !== 2)
            $display("FAIL sub_opmodes got 81x%0d 89x%0d required 81x1 89x2", opm_cnt[8'h81] - s81, opm_cnt[8'h89] - s89);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        int rv, s01, s09, s81, s89;
        logic [47:0] exp;
        qa = '{-131072};
        qb = '{-131072};
        s01 = opm_cnt[8'h01]; s09 = opm_cnt[8'h09];
        s81 = opm_cnt[8'h81]; s89 = opm_cnt[8'h89];
        start_job(1'b0);
        feed(1'b0);
        wait_rv(rv);
        exp = sb.pop_front();
        checks++;
        if (sif.r_data !== exp || exp !== 48'h4_0000_0000) $display("FAIL single_result got %h required %h", sif.r_data, exp);
        else passed++;
        checks++;
        if (opm_cnt[8'h01] - s01 !== 1 || opm_cnt[8'h09] != s09 || opm_cnt[8'h81] != s81 || opm_cnt[8'h89] != s89)
            $display("FAIL single_opmodes got 01x%0d others_changed=%b required 01x1 only", opm_cnt[8'h01] - s01,
                     (opm_cnt[8'h09] != s09) || (opm_cnt[8'h81] != s81) || (opm_cnt[8'h89] != s89));
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_bubbles_backpressure;
        int rv;
        bit stable;
        logic [47:0] held, exp;
        qa = '{3, -2, 7, 1};
        qb = '{4, 5, 7, -1};
        start_job(1'b0);
        sif.r_ready = 1'b0;
        feed(1'b1);
        wait_rv(rv);
        checks++;
        if (rv - last_acc !== 3) $display("FAIL bp_latency got %0d required 3", rv - last_acc);
        else passed++;
        held = sif.r_data;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            start  = (k == 4);
            len_m1 = 10'd0;
            @(posedge clk); #1;
            if (sif.r_valid !== 1'b1 || sif.r_data !== held || sif.s_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (!stable) $display("FAIL bp_hold_stable got unstable result/state required stable HOLD for 10 cycles");
        else passed++;
        sif.r_ready = 1'b1;
        exp = sb.pop_front();
        checks++;
        if (sif.r_data !== exp) $display("FAIL bp_result got %h required %h", sif.r_data, exp);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || sif.s_ready !== 1'b0) $display("FAIL bp_start_ignored got busy=%b s_ready=%b required 0 0", busy, sif.s_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_job;
        int rv;
        logic [47:0] exp;
        qa = '{9, 9, 9};
        qb = '{9, 9, 9};
        start_job(1'b0);
        feed(1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, sif.s_ready, sif.r_valid, dsp_cem, dsp_cep, dsp_rstm, dsp_rstp} !== 7'b0000011 ||
            {dsp_a, dsp_b, dsp_opmode} !== 44'd0 || sif.r_data !== 48'd0)
            $display("FAIL midreset_outputs got ctrl=%b a=%h b=%h opm=%h rdata=%h required 0000011 and zeros",
                     {busy, sif.s_ready, sif.r_valid, dsp_cem, dsp_cep, dsp_rstm, dsp_rstp}, dsp_a, dsp_b, dsp_opmode, sif.r_data);
        else passed++;
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        qa = '{5, 1};
        qb = '{5, 1};
        start_job(1'b0);
        feed(1'b0);
        wait_rv(rv);
        exp = sb.pop_front();
        checks++;
        if (sif.r_data !== exp || exp !== 48'd26) $display("FAIL midreset_next_job got %h required %h (26)", sif.r_data, exp);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int rv;
        logic [47:0] exp;
        qa = '{2, 3};
        qb = '{4, -5};
        start_job(1'b0);
        feed(1'b0);
        wait_rv(rv);
        exp = sb.pop_front();
        checks++;
        if (sif.r_data !== exp) $display("FAIL b2b_first got %h required %h", sif.r_data, exp);
        else passed++;
        qa = '{10, -1};
        qb = '{10, 10};
        start  = 1'b1;
        len_m1 = 10'd1;
        sub    = 1'b1;
        sb.push_back(exp_of(1'b1));
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (sif.s_ready !== 1'b1 || sif.r_valid !== 1'b0) $display("FAIL b2b_direct_load got s_ready=%b rv=%b required 1 0", sif.s_ready, sif.r_valid);
        else passed++;
        feed(1'b0);
        wait_rv(rv);
        exp = sb.pop_front();
        checks++;
        if (sif.r_data !== exp || exp !== (48'd0 - 48'd90)) $display("FAIL b2b_second got %h required %h", sif.r_data, exp);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_full_length;
        int rv;
        logic [47:0] exp;
        qa.delete();
        qb.delete();
        qa.push_back(-131072);
        qb.push_back(131071);
        for (int i = 1; i < 1024; i++) begin
            qa.push_back(int'($urandom_range(0, 262143)) - 131072);
            qb.push_back(int'($urandom_range(0, 262143)) - 131072);
        end
        start_job(1'b0);
        feed(1'b0);
        checks++;
        if (last_acc - first_acc !== 1023) $display("FAIL full_throughput got %0d cycles required 1023", last_acc - first_acc);
        else passed++;
        wait_rv(rv);
        checks++;
        if (rv - last_acc !== 3) $display("FAIL full_latency got %0d required 3", rv - last_acc);
        else passed++;
        exp = sb.pop_front();
        checks++;
        if (sif.r_data !== exp) $display("FAIL full_result got %h required %h", sif.r_data, exp);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_a     = '0;
        sif.s_b     = '0;
        sif.r_ready = 1'b1;
        test_reset();
        test_accumulate();
        test_subtract();
        test_single();
        test_bubbles_backpressure();
        test_reset_mid_job();
        test_back_to_back();
        test_full_length();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drained got %0d entries required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Job-level controller that runs one `DSP_Top` instance as a multiply-accumulate (or multiply-subtract) engine. It accepts a job (beat count, add/sub mode) and a valid/ready stream of 18-bit operand pairs. It drives the DSP operand, opmode, clock-enable and reset ports so the products are summed into P. When done, it returns the 48-bit result over a valid/ready port. It sits between the stream fabric and `DSP_Top`, and its pipeline bookkeeping matches the DSP's MREG/PREG settings.

## Interface
- `MREG`, 1: must equal the DSP's MREG (0/1).
- `PREG`, 1: must equal the DSP's PREG (0/1).
- `CNT_W`, 10: width of the beat counter and of `len_m1`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE, or in HOLD on the result-handshake cycle.
- `len_m1`  in  CNT_W  beats minus one; latched on start.
- `sub`  in  1  0 = accumulate +M, 1 = accumulate −M; latched on start.
- `busy`  out  1  high in any state other than IDLE.
- `s_valid`  in  1  operand beat valid.
- `s_ready`  out  1  high exactly when in LOAD.
- `s_a`  in  18  signed multiplicand.
- `s_b`  in  18  signed multiplier.
- `r_valid`  out  1  result valid.
- `r_ready`  in  1  result accepted.
- `r_data`  out  48  accumulated result.
- `dsp_a`, `dsp_b`  out  18  registered operands to DSP A/B.
- `dsp_opmode`  out  8  DSP opmode.
- `dsp_cem`, `dsp_cep`  out  1  DSP M/P clock enables.
- `dsp_rstm`, `dsp_rstp`  out  1  DSP M/P synchronous resets, active-high.
- `dsp_p`  in  48  DSP P output.

## Operation
- States:
  - IDLE: if start, go to LOAD.
  - LOAD: if a beat is accepted and the counter equals `len_m1`, go to DRAIN.
  - DRAIN: if the last token is at the P-capture stage, go to HOLD.
  - HOLD: if `r_valid & r_ready`, go to LOAD when start is high, otherwise to IDLE.
- Accept (`s_valid & s_ready`):
  - `dsp_a`/`dsp_b` <= `s_a`/`s_b`.
  - Token `t0` <= 1, carrying a first flag (counter==0) and a last flag (counter==`len_m1`).
  - Counter increments.
- Without an accept, `t0` <= 0. Gaps in the stream are bubbles, and the DSP registers hold during bubbles.
- Token pipeline: `t1` = `t0` delayed by MREG cycles; `t2` = `t1` delayed by PREG cycles.
- `dsp_cem` = `t0` valid.
- `dsp_cep` = `t1` valid.
- `dsp_opmode` is combinational from the `t1` token, pre-adder bypassed, CARRYIN 0:
  - first beat: 0x01 (P = 0 + M), or 0x81 when `sub` (P = 0 − M);
  - later beats: 0x09 (P = P + M), or 0x89 (P = P − M);
  - no `t1` token: 0x00.
- `dsp_rstm` = `dsp_rstp` = 1 in IDLE, 0 otherwise.
- When the last token reaches `t2`, `r_data` <= `dsp_p` and `r_valid` <= 1. Both hold until the handshake.
- Arithmetic: 18×18 signed product, sign-extended by the DSP; the sum wraps modulo 2^48 with no saturation and no overflow flag.
- Boundary cases:
  - `len_m1` = 0: a single beat, only the first-beat opmode is used.
  - `len_m1` = all ones: 2^CNT_W beats, and the counter wraps only at the end.
  - start in LOAD or DRAIN: ignored.
  - `r_ready` low: HOLD persists indefinitely.
  - Mid-job `rst_n` low: all state cleared and in-flight tokens discarded. The DSP is cleared on the next IDLE cycles via `dsp_rstm`/`dsp_rstp`.

## Timing
- Reset values: state IDLE; `busy` 0, `s_ready` 0, `r_valid` 0, `r_data` 0, `dsp_a` 0, `dsp_b` 0, `dsp_opmode` 0x00, `dsp_cem` 0, `dsp_cep` 0, `dsp_rstm` 1, `dsp_rstp` 1.
- start at edge E0: `s_ready` is high in the cycle after E0.
- Last beat accepted at edge Ek: `r_valid` rises at edge Ek+1+MREG+PREG (Ek+3 for the defaults).
- Back-to-back beats give one product per cycle.
- Job throughput: N + 1 + MREG + PREG + 1 cycles when `r_ready` is high.

## Structure
- Shared package `dsp_seq_pkg`:
  - state enum;
  - opmode constants `OPM_IDLE=0x00`, `OPM_FIRST=0x01`, `OPM_ACC=0x09`, and SUB bit 7;
  - token struct {valid, first, last}.
- One sub-module, `dsp_tok_delay`: a parameterized 0/1-stage token delay line, instantiated for MREG and for PREG.

## Test plan
- Accumulate, 4 beats: a/b pairs (3,4), (−2,5), (7,7), (1,−1) -> `r_data` = 48'd50, `r_valid` 3 cycles after the last accept.
- Subtract, 3 beats: `sub`=1 with pairs (1,1), (2,2), (3,3) -> `r_data` = −14 (0xFFFF_FFFF_FFF2).
- Single beat: `len_m1`=0 with (−131072, −131072) -> `r_data` = 2^34; only opmode 0x01 is ever seen.
- Bubbles and backpressure: `s_valid` toggled randomly, `r_ready` held low 10 cycles -> same result as the gap-free run; `r_valid` and `r_data` stable while stalled; start ignored until the handshake.
- Reset mid-job: `rst_n` pulsed low during DRAIN -> all outputs at reset values immediately; a subsequent 2-beat job (5,5), (1,1) -> 26.
- Back-to-back jobs: start held high during the HOLD handshake -> LOAD follows directly; the second job's result is unaffected by the first.
